// File: rtl/dram_controller_pkg.sv
// Shared encodings for the Wishbone-to-memory-interface bridge:
// memory command codes and the front/back FSM state types.
package dram_controller_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [2:0] {
    F_IDLE,
    F_PUSH,
    F_WAIT_RESP,
    F_ACK,
    F_RELEASE
  } front_state_t;

  typedef enum logic [1:0] {
    B_IDLE,
    B_CMD,
    B_WDATA,
    B_RDWAIT
  } back_state_t;

endpackage

// File: rtl/dram_controller_sync_fifo.sv
// Single-clock FIFO with show-ahead output; full/empty come from
// read/write pointers that carry one extra wrap bit.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: a flush only has to clear the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/dram_controller.sv
// Wishbone slave front end feeding a memory command/write/read-return
// back end through a request FIFO and a response FIFO.
//
// state       | meaning
// F_IDLE      | waiting for cyc_i & stb_i
// F_PUSH      | enqueue request once the request FIFO has room
// F_WAIT_RESP | pop response; register it for ack or discard if cyc_i dropped
// F_ACK       | ack_o high for one cycle
// F_RELEASE   | wait for cyc_i and stb_i both low
// B_IDLE      | pop request once calibrated
// B_CMD       | command (and write data) offered
// B_WDATA     | command accepted, finishing write data / zero response push
// B_RDWAIT    | waiting for read return, holding it if response FIFO is full
module dram_controller
  import dram_controller_pkg::*;
#(
  parameter int WORD_SIZE  = 128,
  parameter int ADDR_WIDTH = 28,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  user_clk_i,
  input  logic                  rst_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [31:0]           addr_i,
  input  logic [WORD_SIZE-1:0]  data_i,
  output logic [WORD_SIZE-1:0]  data_o,
  output logic                  ack_o,
  output logic                  req_empty,
  output logic                  resp_empty,
  input  logic                  init_calib_complete_i,
  output logic [ADDR_WIDTH-1:0] app_addr_o,
  output logic [2:0]            app_cmd_o,
  output logic                  app_en_o,
  input  logic                  app_rdy_i,
  output logic [WORD_SIZE-1:0]  app_wdf_data_o,
  output logic                  app_wdf_wren_o,
  output logic                  app_wdf_end_o,
  input  logic                  app_wdf_rdy_i,
  input  logic [WORD_SIZE-1:0]  app_rd_data_i,
  input  logic                  app_rd_data_valid_i
);

  localparam int OFF   = $clog2(WORD_SIZE / 8);
  localparam int REQ_W = 1 + 32 + WORD_SIZE;

  function automatic logic [ADDR_WIDTH-1:0] app_addr_of(input logic [31:0] byte_addr);
    logic [ADDR_WIDTH-1:0] a;
    a = byte_addr[ADDR_WIDTH-1:0];
    a[OFF-1:0] = '0;
    return a;
  endfunction

  logic                 req_push, req_pop, req_full;
  logic [REQ_W-1:0]     req_din, req_dout;
  logic                 resp_push, resp_pop, resp_full;
  logic [WORD_SIZE-1:0] resp_din, resp_dout;

  front_state_t         front_q, front_d;
  logic                 drop_q, drop_d;
  logic [WORD_SIZE-1:0] data_q, data_d;

  back_state_t           back_q, back_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0]  wdata_q, wdata_d;
  logic                  wdf_done_q, wdf_done_d;
  logic [WORD_SIZE-1:0]  rdat_q, rdat_d;
  logic                  rheld_q, rheld_d;
  logic                  wdf_ok;

  assign req_din = {we_i, addr_i, data_i};

  sync_fifo #(.WIDTH(REQ_W), .DEPTH(FIFO_DEPTH)) u_req_fifo (
    .clk(user_clk_i), .rst(rst_i), .push(req_push), .din(req_din),
    .pop(req_pop), .dout(req_dout), .full(req_full), .empty(req_empty)
  );

  sync_fifo #(.WIDTH(WORD_SIZE), .DEPTH(FIFO_DEPTH)) u_resp_fifo (
    .clk(user_clk_i), .rst(rst_i), .push(resp_push), .din(resp_din),
    .pop(resp_pop), .dout(resp_dout), .full(resp_full), .empty(resp_empty)
  );

  always_comb begin
    front_d  = front_q;
    drop_d   = drop_q;
    data_d   = data_q;
    req_push = 1'b0;
    resp_pop = 1'b0;
    case (front_q)
      F_IDLE: begin
        if (cyc_i && stb_i) begin
          front_d = F_PUSH;
          drop_d  = 1'b0;
        end
      end
      F_PUSH: begin
        drop_d = drop_q || !cyc_i;
        if (!req_full) begin
          req_push = 1'b1;
          front_d  = F_WAIT_RESP;
        end
      end
      F_WAIT_RESP: begin
        // An abandoned cycle still drains its response so the FIFOs stay paired.
        drop_d = drop_q || !cyc_i;
        if (!resp_empty) begin
          resp_pop = 1'b1;
          if (drop_d) begin
            front_d = F_IDLE;
          end else begin
            data_d  = resp_dout;
            front_d = F_ACK;
          end
        end
      end
      F_ACK:     front_d = F_RELEASE;
      F_RELEASE: if (!cyc_i && !stb_i) front_d = F_IDLE;
      default:   front_d = F_IDLE;
    endcase
  end

  always_comb begin
    back_d         = back_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wdf_done_d     = wdf_done_q;
    rdat_d         = rdat_q;
    rheld_d        = rheld_q;
    wdf_ok         = 1'b0;
    req_pop        = 1'b0;
    resp_push      = 1'b0;
    resp_din       = '0;
    app_en_o       = 1'b0;
    app_wdf_wren_o = 1'b0;
    case (back_q)
      B_IDLE: begin
        if (!req_empty && init_calib_complete_i) begin
          req_pop    = 1'b1;
          we_d       = req_dout[REQ_W-1];
          addr_d     = app_addr_of(req_dout[WORD_SIZE +: 32]);
          wdata_d    = req_dout[WORD_SIZE-1:0];
          wdf_done_d = 1'b0;
          rheld_d    = 1'b0;
          back_d     = B_CMD;
        end
      end
      B_CMD: begin
        app_en_o = 1'b1;
        if (we_q) begin
          app_wdf_wren_o = !wdf_done_q;
          wdf_ok         = wdf_done_q || app_wdf_rdy_i;
          wdf_done_d     = wdf_ok;
          if (app_rdy_i) begin
            if (wdf_ok && !resp_full) begin
              resp_push = 1'b1;
              back_d    = B_IDLE;
            end else begin
              back_d = B_WDATA;
            end
          end
        end else if (app_rdy_i) begin
          back_d = B_RDWAIT;
        end
      end
      B_WDATA: begin
        app_wdf_wren_o = !wdf_done_q;
        wdf_ok         = wdf_done_q || app_wdf_rdy_i;
        wdf_done_d     = wdf_ok;
        if (wdf_ok && !resp_full) begin
          resp_push = 1'b1;
          back_d    = B_IDLE;
        end
      end
      B_RDWAIT: begin
        // Memory cannot be back-pressured, so a return that meets a full FIFO is parked.
        if (rheld_q) begin
          if (!resp_full) begin
            resp_push = 1'b1;
            resp_din  = rdat_q;
            back_d    = B_IDLE;
          end
        end else if (app_rd_data_valid_i) begin
          if (!resp_full) begin
            resp_push = 1'b1;
            resp_din  = app_rd_data_i;
            back_d    = B_IDLE;
          end else begin
            rdat_d  = app_rd_data_i;
            rheld_d = 1'b1;
          end
        end
      end
      default: back_d = B_IDLE;
    endcase
  end

  always_ff @(posedge user_clk_i or posedge rst_i) begin
    if (rst_i) begin
      front_q    <= F_IDLE;
      drop_q     <= 1'b0;
      data_q     <= '0;
      back_q     <= B_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wdf_done_q <= 1'b0;
      rdat_q     <= '0;
      rheld_q    <= 1'b0;
    end else begin
      front_q    <= front_d;
      drop_q     <= drop_d;
      data_q     <= data_d;
      back_q     <= back_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wdf_done_q <= wdf_done_d;
      rdat_q     <= rdat_d;
      rheld_q    <= rheld_d;
    end
  end

  assign ack_o          = (front_q == F_ACK);
  assign data_o         = data_q;
  assign app_addr_o     = addr_q;
  assign app_cmd_o      = we_q ? CMD_WRITE : CMD_READ;
  assign app_wdf_data_o = wdata_q;
  assign app_wdf_end_o  = app_wdf_wren_o;

endmodule

// File: tb/tb_dram_controller.sv
// Bench for dram_controller: vector table plus hand-written stall, calibration,
// held-strobe and mid-read reset sequences against a simple memory model.
module tb_dram_controller;
  import dram_controller_pkg::*;

  localparam int WS = 128;
  localparam int AW = 28;

  logic          clk = 1'b0;
  logic          rst, cyc, stb, we;
  logic [31:0]   addr;
  logic [WS-1:0] wdata, data_o, wdf_data, rd_data;
  logic          ack, req_empty, resp_empty, init_calib;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en, app_rdy, wdf_wren, wdf_end, wdf_rdy, rd_valid;

  dram_controller #(.WORD_SIZE(WS), .ADDR_WIDTH(AW), .FIFO_DEPTH(8)) dut (
    .user_clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we),
    .addr_i(addr), .data_i(wdata), .data_o(data_o), .ack_o(ack),
    .req_empty(req_empty), .resp_empty(resp_empty),
    .init_calib_complete_i(init_calib), .app_addr_o(app_addr),
    .app_cmd_o(app_cmd), .app_en_o(app_en), .app_rdy_i(app_rdy),
    .app_wdf_data_o(wdf_data), .app_wdf_wren_o(wdf_wren),
    .app_wdf_end_o(wdf_end), .app_wdf_rdy_i(wdf_rdy),
    .app_rd_data_i(rd_data), .app_rd_data_valid_i(rd_valid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_acks = 0;
  int n_cmds = 0;
  logic [WS-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [WS-1:0] act, input logic [WS-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Memory model: commits writes on command acceptance, returns reads after rd_lat cycles.
  logic [WS-1:0] mem [logic [AW-1:0]];
  int            rd_lat = 0;
  int            rd_cnt = 0;
  bit            rd_pending = 0;
  bit            fire_rd;
  logic [AW-1:0] rd_a, last_wr_addr;

  initial begin
    rd_valid = 1'b0;
    rd_data  = '0;
    last_wr_addr = '0;
    rd_a = '0;
    forever begin
      @(negedge clk);
      fire_rd = 0;
      if (!rst && app_en && app_rdy) begin
        n_cmds++;
        if (app_cmd == CMD_WRITE) begin
          mem[app_addr] = wdf_data;
          last_wr_addr  = app_addr;
        end else begin
          fire_rd = 1;
          rd_a    = app_addr;
        end
      end
      @(posedge clk);
      #1;
      rd_valid = 1'b0;
      if (fire_rd) begin
        rd_pending = 1;
        rd_cnt     = rd_lat;
      end
      if (rd_pending) begin
        if (rd_cnt == 0) begin
          rd_valid   = 1'b1;
          rd_data    = mem.exists(rd_a) ? mem[rd_a] : '0;
          rd_pending = 0;
        end else begin
          rd_cnt--;
        end
      end
    end
  end

  // Scoreboard: every ack pops the expected data pushed when the transfer started.
  initial begin
    forever begin
      @(negedge clk);
      if (ack) begin
        n_acks++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_ack: got data %h, want no ack", data_o);
        end else begin
          chk("ack_data", data_o, exp_q.pop_front());
        end
      end
    end
  end

  task automatic start_xfer(input logic w, input logic [31:0] a, input logic [WS-1:0] d,
                            input logic [WS-1:0] e);
    @(posedge clk);
    #1;
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    repeat (300) begin
      @(posedge clk);
      #1;
      lat++;
      if (ack) return;
    end
    lat = -1;
  endtask

  task automatic end_xfer(input bit hold);
    if (hold) begin
      @(posedge clk);
      #1;
    end
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic xfer(input logic w, input logic [31:0] a, input logic [WS-1:0] d,
                      input logic [WS-1:0] e, input int exp_lat, input bit hold);
    int lat;
    start_xfer(w, a, d, e);
    wait_ack(lat);
    end_xfer(hold);
    if (exp_lat > 0) chk_i("latency", lat, exp_lat);
    else if (lat < 0) chk_i("ack_timeout", lat, 1);
    repeat (2) @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    chk_i({tag, "_ack"}, int'(ack), 0);
    chk({tag, "_data_o"}, data_o, '0);
    chk_i({tag, "_app_en"}, int'(app_en), 0);
    chk_i({tag, "_wdf_wren"}, int'(wdf_wren), 0);
    chk_i({tag, "_wdf_end"}, int'(wdf_end), 0);
    chk_i({tag, "_app_addr"}, int'(app_addr), 0);
    chk_i({tag, "_req_empty"}, int'(req_empty), 1);
    chk_i({tag, "_resp_empty"}, int'(resp_empty), 1);
  endtask

  typedef struct {
    logic          w;
    logic [31:0]   a;
    logic [WS-1:0] d;
    logic [WS-1:0] e;
    int            lat;
  } vec_t;

  localparam logic [WS-1:0] DA  = 128'hAABBCCDDEEFF00112233445566778899;
  localparam logic [WS-1:0] DB  = 128'h0123456789ABCDEF0FEDCBA987654321;
  localparam logic [WS-1:0] DC  = 128'hDEADBEEF_CAFEF00D_13579BDF_2468ACE0;
  localparam logic [WS-1:0] DD  = 128'h11112222333344445555666677778888;
  localparam logic [WS-1:0] DE  = 128'hF0F0F0F0_0F0F0F0F_A5A5A5A5_5A5A5A5A;
  localparam logic [WS-1:0] DF  = 128'h99990000AAAA1111BBBB2222CCCC3333;
  localparam logic [WS-1:0] DG  = 128'h0000000000000000FFFFFFFFFFFFFFFF;

  vec_t vt[7];

  initial begin
    int lat, c0, a0;
    bit seen, stable;

    vt[0] = '{1'b1, 32'h10, DA, '0, 5};
    vt[1] = '{1'b0, 32'h10, '0, DA, 6};
    vt[2] = '{1'b1, 32'h20, DB, '0, 5};
    vt[3] = '{1'b0, 32'h20, '0, DB, 6};
    vt[4] = '{1'b1, 32'h3F, DC, '0, 5};
    vt[5] = '{1'b0, 32'h30, '0, DC, 6};
    vt[6] = '{1'b0, 32'h1C, '0, DA, 6};

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    init_calib = 1'b1; app_rdy = 1'b1; wdf_rdy = 1'b1;
    idle(3);
    reset_checks("reset");
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 7; i++) xfer(vt[i].w, vt[i].a, vt[i].d, vt[i].e, vt[i].lat, 1'b0);
    idle(3);
    chk_i("table_acks", n_acks, 7);
    chk_i("table_cmds", n_cmds, 7);
    chk_i("addr_mask", int'(last_wr_addr), 32'h30);

    // Strobe held one cycle past ack must not start a second transfer.
    c0 = n_cmds; a0 = n_acks;
    xfer(1'b1, 32'h60, DG, '0, 5, 1'b1);
    idle(8);
    chk_i("hold_cmds", n_cmds - c0, 1);
    chk_i("hold_acks", n_acks - a0, 1);

    // Calibration gate.
    init_calib = 1'b0;
    c0 = n_cmds;
    start_xfer(1'b1, 32'h40, DD, '0);
    seen = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (app_en) seen = 1;
    end
    chk_i("calib_no_cmd", int'(seen), 0);
    chk_i("calib_req_pending", int'(req_empty), 0);
    init_calib = 1'b1;
    wait_ack(lat);
    end_xfer(1'b0);
    if (lat < 0) chk_i("calib_ack_timeout", lat, 1);
    idle(4);
    chk_i("calib_one_cmd", n_cmds - c0, 1);
    xfer(1'b0, 32'h40, '0, DD, 6, 1'b0);

    // Both handshakes stalled, then command accepted before write data.
    app_rdy = 1'b0; wdf_rdy = 1'b0;
    a0 = n_acks;
    start_xfer(1'b1, 32'h50, DE, '0);
    for (int k = 0; k < 20 && !app_en; k++) begin
      @(posedge clk);
      #1;
    end
    stable = 1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (!(app_en && wdf_wren && wdf_end && app_addr == 28'h50 && wdf_data == DE)) stable = 0;
    end
    chk_i("stall_held", int'(stable), 1);
    app_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk_i("cmd_done_wdata_held", int'({app_en, wdf_wren, wdf_end}), 3);
    wdf_rdy = 1'b1;
    wait_ack(lat);
    end_xfer(1'b0);
    if (lat < 0) chk_i("stall_ack_timeout", lat, 1);
    idle(4);
    chk_i("stall_one_ack", n_acks - a0, 1);
    xfer(1'b0, 32'h50, '0, DE, 6, 1'b0);

    // Reset while a read is waiting for its data; late data must be ignored.
    rd_lat = 12;
    a0 = n_acks;
    start_xfer(1'b0, 32'h10, '0, DA);
    idle(5);
    rst = 1'b1;
    cyc = 1'b0; stb = 1'b0;
    exp_q.delete();
    #1;
    reset_checks("midrst");
    idle(1);
    rst = 1'b0;
    idle(20);
    chk_i("midrst_no_ack", n_acks - a0, 0);
    chk_i("midrst_resp_empty", int'(resp_empty), 1);
    rd_lat = 0;
    xfer(1'b1, 32'h20, DF, '0, 5, 1'b0);
    xfer(1'b0, 32'h20, '0, DF, 6, 1'b0);
    idle(3);
    chk_i("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dram_controller.md
DRAM_CONTROLLER -- requirements
Module: dram_controller

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 128, data width of the bus, FIFOs and memory interface in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 28, memory-interface address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8 (power of two), entries per request/response FIFO.
REQ-004 SHALL provide user_clk_i, input, 1, sole clock; everything is sampled on its rising edge.
REQ-005 SHALL provide rst_i, input, 1, asynchronous active-high reset.
REQ-006 SHALL provide cyc_i, stb_i, we_i, input, 1 each, Wishbone cycle, strobe and write-enable.
REQ-007 SHALL provide addr_i, input, 32, byte address.
REQ-008 SHALL provide data_i, input, WORD_SIZE, write data.
REQ-009 SHALL provide data_o, output, WORD_SIZE, read data, valid while ack_o=1.
REQ-010 SHALL provide ack_o, output, 1, one-cycle transfer acknowledge.
REQ-011 SHALL provide req_empty and resp_empty, output, 1 each, request/response FIFO empty flags.
REQ-012 SHALL provide init_calib_complete_i, input, 1, memory interface ready for commands.
REQ-013 SHALL provide app_addr_o (ADDR_WIDTH), app_cmd_o (3; 000 write, 001 read), app_en_o (1), all outputs, memory command channel.
REQ-014 SHALL provide app_rdy_i, input, 1, command accepted when app_en_o=1 and app_rdy_i=1.
REQ-015 SHALL provide app_wdf_data_o (WORD_SIZE), app_wdf_wren_o and app_wdf_end_o (1 each), outputs, write-data channel.
REQ-016 SHALL provide app_wdf_rdy_i, input, 1, write data accepted when app_wdf_wren_o=1 and app_wdf_rdy_i=1.
REQ-017 SHALL provide app_rd_data_i (WORD_SIZE) and app_rd_data_valid_i (1), inputs, read return channel.

Function
REQ-018 SHALL run a front FSM IDLE -> PUSH -> WAIT_RESP -> ACK -> RELEASE -> IDLE.
REQ-019 IDLE SHALL move to PUSH when cyc_i&stb_i=1; PUSH SHALL enqueue {we_i, addr_i, data_i} into the request FIFO on the first cycle it is not full (stall while full).
REQ-020 WAIT_RESP SHALL pop the response FIFO when not empty and register its data into data_o; ACK SHALL hold ack_o=1 for exactly one cycle.
REQ-021 RELEASE SHALL ignore cyc_i/stb_i until both are sampled low for one cycle, so a strobe held one cycle past ack_o never issues a second transfer.
REQ-022 Dropping cyc_i before ack_o SHALL NOT cancel an enqueued request; its response is popped and discarded, with no ack_o.
REQ-023 SHALL run a back FSM B_IDLE -> B_CMD -> (B_WDATA | B_RDWAIT) -> B_IDLE with at most one outstanding request.
REQ-024 B_IDLE SHALL pop the request FIFO only when it is not empty and init_calib_complete_i=1.
REQ-025 app_addr_o SHALL be addr_i[ADDR_WIDTH-1:0] with the low log2(WORD_SIZE/8) bits forced to 0.
REQ-026 Writes SHALL drive app_wdf_wren_o=app_wdf_end_o=1 together with app_en_o, each held until its own handshake, the two completing in either order.
REQ-027 A write SHALL push a response of all zeros once both handshakes complete; data_o then reads 0.
REQ-028 A read SHALL push app_rd_data_i into the response FIFO on the first app_rd_data_valid_i=1 after command acceptance; app_rd_data_valid_i in other states SHALL be ignored.
REQ-029 The back FSM SHALL stall, without dropping data, while the response FIFO is full.
REQ-030 Each FIFO SHALL support simultaneous push and pop; full/empty flags SHALL be derived from pointers with one extra wrap bit.
REQ-031 Minimum latency from stb_i to ack_o with zero-wait memory SHALL be 5 cycles for writes and 5 + read-return delay for reads.

Reset
REQ-032 While rst_i=1, ack_o, data_o, app_en_o, app_wdf_wren_o, app_wdf_end_o and app_addr_o SHALL be 0, req_empty=resp_empty=1, both FSMs IDLE.
REQ-033 Reset mid-transaction SHALL flush both FIFOs and abandon outstanding commands; read data arriving after reset SHALL be ignored.

Structure
REQ-034 A shared package SHALL hold the app_cmd encodings (CMD_WRITE=3'b000, CMD_READ=3'b001) and both FSM state enums.
REQ-035 A single parameterised sub-module sync_fifo (WIDTH, DEPTH) SHALL be instantiated twice: request (1+32+WORD_SIZE bits) and response (WORD_SIZE bits).

Verification
REQ-036 Write 0x10 with 0xAABBCCDDEEFF00112233445566778899, then read 0x10 -> exactly one ack_o per transfer; data_o = 0xAABBCCDDEEFF00112233445566778899.
REQ-037 init_calib_complete_i=0 for 50 cycles, then write -> req_empty=0 and app_en_o=0 until calibration, then one write command.
REQ-038 app_rdy_i=0 and app_wdf_rdy_i=0 for 5 cycles -> app_en_o and app_wdf_wren_o held stable, one ack_o afterwards.
REQ-039 stb_i/cyc_i held one cycle after ack_o -> exactly one memory command issued.
REQ-040 rst_i pulsed while a read waits for data -> all outputs at reset values; a later read of 0x20 returns the correct data.
